// File: rtl/wb_burst_ram.sv
// wb_burst_ram: Wishbone B3 single-port RAM slave with classic cycles and registered-feedback
// incrementing bursts (linear, wrap-4/8/16); words beyond DEPTH answer with err.
module wb_burst_ram #(
   parameter int    DEPTH     = 8192,
   parameter int    AW        = 32,
   parameter string INIT_FILE = ""
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic [AW-1:0] wb_adr_i,
   input  logic [31:0]   wb_dat_i,
   input  logic [3:0]    wb_sel_i,
   input  logic          wb_we_i,
   input  logic          wb_cyc_i,
   input  logic          wb_stb_i,
   input  logic [2:0]    wb_cti_i,
   input  logic [1:0]    wb_bte_i,
   output logic [31:0]   wb_dat_o,
   output logic          wb_ack_o,
   output logic          wb_err_o,
   output logic          wb_rty_o
);

   // state   | meaning
   // IDLE    | nothing on the bus; a request is answered next cycle
   // CLASSIC | single response (ack or err) on the bus, drops next cycle
   // BURST   | burst in flight; ack follows the predicted next word

   localparam int WW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, CLASSIC, BURST} state_t;

   state_t        state, state_n;
   logic [31:0]   mem [DEPTH];
   logic          ack_q, err_q, ack_n, err_n;
   logic [WW-1:0] wi, exp_wi, exp_n, nxt_wi, rd_wi, wrap_mask;
   logic          req, in_range, match, cti_inc, last_lin, fresh, beat_ok;
   logic          rd_en, wr_en;
   logic          unused_adr;

   assign req        = wb_cyc_i & wb_stb_i;
   assign wi         = wb_adr_i[WW+1:2];
   assign in_range   = ~|wb_adr_i[AW-1:WW+2];
   assign match      = in_range && (wi == exp_wi);
   assign cti_inc    = (wb_cti_i == 3'b010);
   assign last_lin   = (wb_bte_i == 2'b00) && (&exp_wi);
   assign fresh      = (state == IDLE) || ((state == BURST) && !ack_q);
   assign beat_ok    = (state == BURST) && ack_q && req && match;
   assign unused_adr = &{1'b0, wb_adr_i[1:0]};

   always_comb begin
      case (wb_bte_i)
         2'b01:   wrap_mask = WW'(3);
         2'b10:   wrap_mask = WW'(7);
         2'b11:   wrap_mask = WW'(15);
         default: wrap_mask = '1;
      endcase
   end

   // Linear is the degenerate wrap whose block is the whole array.
   assign nxt_wi = (exp_wi & ~wrap_mask) | ((exp_wi + WW'(1)) & wrap_mask);

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state  <= IDLE;
         ack_q  <= 1'b0;
         err_q  <= 1'b0;
         exp_wi <= '0;
      end else begin
         state  <= state_n;
         ack_q  <= ack_n;
         err_q  <= err_n;
         exp_wi <= exp_n;
      end
   end

   always_comb begin
      state_n = state;
      if (!wb_cyc_i) begin
         state_n = IDLE;
      end else if (fresh) begin
         if (req) state_n = (cti_inc && in_range) ? BURST : CLASSIC;
      end else if (state == CLASSIC) begin
         state_n = IDLE;
      end else if (wb_stb_i) begin
         if (!match || !cti_inc) state_n = IDLE;
         else if (last_lin)      state_n = CLASSIC;
         else                    state_n = BURST;
      end
   end

   always_comb begin
      ack_n = 1'b0;
      err_n = 1'b0;
      exp_n = exp_wi;
      rd_en = 1'b0;
      rd_wi = wi;
      if (req && fresh) begin
         if (in_range) begin
            ack_n = 1'b1;
            rd_en = 1'b1;
            exp_n = wi;
         end else begin
            err_n = 1'b1;
         end
      end else if (beat_ok && cti_inc) begin
         // Read the predicted word now so its data is registered for the next beat.
         if (last_lin) begin
            err_n = 1'b1;
         end else begin
            ack_n = 1'b1;
            rd_en = 1'b1;
            rd_wi = nxt_wi;
            exp_n = nxt_wi;
         end
      end
   end

   assign wr_en = !wb_rst_i && ack_q && req && wb_we_i && in_range
                  && ((state == CLASSIC) || (wi == exp_wi));

   always_ff @(posedge wb_clk_i) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wb_sel_i[b]) mem[wi][8*b +: 8] <= wb_dat_i[8*b +: 8];
         end
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i)   wb_dat_o <= '0;
      else if (rd_en) wb_dat_o <= mem[rd_wi];
   end

   assign wb_ack_o = ack_q;
   assign wb_err_o = err_q;
   assign wb_rty_o = 1'b0;

endmodule
